// File: rtl/debug_uart_rx_pkg.sv
// Shared types and constants for the host debug command receiver:
// receiver state encoding, command bytes and the baud divider helper.
package debug_uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_IDLE = 3'd4
   } rx_state_e;

   localparam logic [7:0] CMD_STEP      = 8'h6E;
   localparam logic [7:0] CMD_RST_ON    = 8'h52;
   localparam logic [7:0] CMD_RST_OFF   = 8'h72;
   localparam logic [7:0] CMD_VIEW_BASE = 8'h30;

   // Clocks per bit, or half of that for the mid-start-bit sample.
   function automatic int uart_div(input int clk_freq, input int baud, input bit half);
      int bit_div;
      bit_div = clk_freq / baud;
      return half ? (bit_div / 2) : bit_div;
   endfunction

endpackage

// File: rtl/debug_uart_rx_if.sv
// Board-side bundle of the debug receiver: RX pin in, control outputs and
// the receiver state for observation.
interface debug_uart_rx_if;
   // rx_valid is a one-cycle pulse qualifying rx_data; there is no ready,
   // the consumer must take the byte in that cycle. frame_err is a
   // one-cycle pulse and never coincides with rx_valid.
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       step_out;
   logic       cpu_reset;
   logic [1:0] view_sel;
   logic [2:0] rx_state;

   modport master (
      output rx,
      input  rx_data, rx_valid, frame_err, step_out, cpu_reset, view_sel, rx_state
   );

   modport slave (
      input  rx,
      output rx_data, rx_valid, frame_err, step_out, cpu_reset, view_sel, rx_state
   );
endinterface

// File: rtl/debug_uart_rx_core.sv
// 8N1 UART receiver: input synchroniser, baud counter, framing FSM and
// shift register. Emits a byte pulse or a framing-error pulse per frame.
module uart_rx_core
   import debug_uart_pkg::*;
#(
   parameter int BIT_DIV  = 16,
   parameter int HALF_DIV = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       frame_err_o,
   output logic [2:0] state_o
);

   localparam int CW = $clog2(BIT_DIV);
   localparam logic [CW-1:0] BIT_M1  = CW'(BIT_DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF_DIV - 1);

   localparam logic [2:0] ST_IDLE      = RX_IDLE;
   localparam logic [2:0] ST_START     = RX_START;
   localparam logic [2:0] ST_DATA      = RX_DATA;
   localparam logic [2:0] ST_STOP      = RX_STOP;
   localparam logic [2:0] ST_WAIT_IDLE = RX_WAIT_IDLE;

   logic          rx_meta_q, rx_s_q;
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rx_s_q) begin
               cnt_d   = HALF_M1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == '0) begin
               if (!rx_s_q) begin
                  state_d   = ST_DATA;
                  bit_idx_d = 3'd0;
                  cnt_d     = BIT_M1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_s_q, shift_q[7:1]};
               cnt_d   = BIT_M1;
               if (bit_idx_q == 3'd7) state_d = ST_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == '0) begin
               if (rx_s_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         // A held-low line (break) must not decode as repeated 0x00 bytes.
         ST_WAIT_IDLE: begin
            if (rx_s_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign rx_data_o   = data_q;
   assign rx_valid_o  = valid_q;
   assign frame_err_o = ferr_q;
   assign state_o     = state_q;

endmodule

// File: rtl/debug_uart_rx.sv
// Host debug command receiver: UART bytes in, CPU step pulse, CPU reset
// level and display view select out.
module debug_uart_rx
   import debug_uart_pkg::*;
#(
   parameter int CLK_FREQ    = 100_000_000,
   parameter int BAUD        = 115200,
   parameter int STEP_CYCLES = 1_000_000
) (
   input logic            clock,
   input logic            reset,
   debug_uart_rx_if.slave bus
);

   localparam int BIT_DIV  = uart_div(CLK_FREQ, BAUD, 1'b0);
   localparam int HALF_DIV = uart_div(CLK_FREQ, BAUD, 1'b1);
   localparam int SW       = $clog2(STEP_CYCLES + 1);
   localparam logic [SW-1:0] STEP_LOAD = SW'(STEP_CYCLES);

   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic [2:0]    rx_state;
   logic [SW-1:0] step_cnt_q, step_cnt_d;
   logic          step_q;
   logic          cpu_reset_q, cpu_reset_d;
   logic [1:0]    view_q, view_d;

   uart_rx_core #(
      .BIT_DIV  (BIT_DIV),
      .HALF_DIV (HALF_DIV)
   ) u_core (
      .clock       (clock),
      .reset       (reset),
      .rx_i        (bus.rx),
      .rx_data_o   (rx_data),
      .rx_valid_o  (rx_valid),
      .frame_err_o (frame_err),
      .state_o     (rx_state)
   );

   // A step command landing during a pulse is dropped, not queued.
   always_comb begin
      cpu_reset_d = cpu_reset_q;
      view_d      = view_q;
      step_cnt_d  = (step_cnt_q != '0) ? step_cnt_q - SW'(1) : step_cnt_q;
      if (rx_valid) begin
         case (rx_data)
            CMD_STEP:    if (step_cnt_q == '0) step_cnt_d = STEP_LOAD;
            CMD_RST_ON:  cpu_reset_d = 1'b1;
            CMD_RST_OFF: cpu_reset_d = 1'b0;
            default: begin
               if (rx_data[7:2] == CMD_VIEW_BASE[7:2]) view_d = rx_data[1:0];
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         step_cnt_q  <= '0;
         step_q      <= 1'b0;
         cpu_reset_q <= 1'b1;
         view_q      <= 2'b00;
      end else begin
         step_cnt_q  <= step_cnt_d;
         step_q      <= (step_cnt_d != '0);
         cpu_reset_q <= cpu_reset_d;
         view_q      <= view_d;
      end
   end

   assign bus.rx_data   = rx_data;
   assign bus.rx_valid  = rx_valid;
   assign bus.frame_err = frame_err;
   assign bus.rx_state  = rx_state;
   assign bus.step_out  = step_q;
   assign bus.cpu_reset = cpu_reset_q;
   assign bus.view_sel  = view_q;

endmodule

// File: tb/tb_debug_uart_rx.sv
// Directed bench for debug_uart_rx at 16 clocks per bit: command decode,
// step pulse width, framing error, glitch rejection and mid-frame reset.
module tb_debug_uart_rx;
  import debug_uart_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_err    = 0;

  debug_uart_rx_if if1 ();
  debug_uart_rx_if if2 ();

  debug_uart_rx #(.CLK_FREQ(16), .BAUD(1), .STEP_CYCLES(5)) u_dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (if1)
  );

  debug_uart_rx #(.CLK_FREQ(16), .BAUD(1), .STEP_CYCLES(400)) u_dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (if2)
  );

  // clock/reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // event monitor, sampled away from the active edge
  int v1_cnt = 0, v1_cyc = 0, f1_cnt = 0, both_cnt = 0, v2_cnt = 0;
  logic [7:0] v1_data = 8'h00;
  int rst_chg_cyc = 0, view_chg_cyc = 0;
  logic rst_prev = 1'b1;
  logic [1:0] view_prev = 2'b00;
  int s1_rise = 0, s1_rise_cyc = 0, s1_run = 0, s1_width = 0;
  int s2_rise = 0, s2_run = 0, s2_width = 0;
  logic s1_prev = 1'b0, s2_prev = 1'b0;

  always @(negedge clock) begin
    if (if1.rx_valid) begin v1_cnt++; v1_cyc = cyc; v1_data = if1.rx_data; end
    if (if1.frame_err) f1_cnt++;
    if (if1.rx_valid && if1.frame_err) both_cnt++;
    if (if2.rx_valid) v2_cnt++;
    if (if1.cpu_reset !== rst_prev) rst_chg_cyc = cyc;
    if (if1.view_sel !== view_prev) view_chg_cyc = cyc;
    rst_prev  = if1.cpu_reset;
    view_prev = if1.view_sel;
    if (if1.step_out && !s1_prev) begin s1_rise++; s1_rise_cyc = cyc; s1_run = 0; end
    if (if1.step_out) s1_run++;
    if (!if1.step_out && s1_prev) s1_width = s1_run;
    s1_prev = if1.step_out;
    if (if2.step_out && !s2_prev) begin s2_rise++; s2_run = 0; end
    if (if2.step_out) s2_run++;
    if (!if2.step_out && s2_prev) s2_width = s2_run;
    s2_prev = if2.step_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: one 8N1 frame, 16 clocks per bit; abort_clks > 0 stops early
  task automatic send_byte(input int which, input logic [7:0] b, input logic stop,
                           input int abort_clks, output int t_start);
    logic v;
    @(negedge clock);
    t_start = cyc;
    for (int c = 0; c < 160; c++) begin
      if (c < 16)       v = 1'b0;
      else if (c < 144) v = b[(c / 16) - 1];
      else              v = stop;
      if (which == 1) if1.rx = v;
      else            if2.rx = v;
      @(negedge clock);
      if (abort_clks != 0 && c + 1 == abort_clks) return;
    end
  endtask

  int t;

  initial begin
    if1.rx = 1'b1;
    if2.rx = 1'b1;
    reset  = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    chk("rst_cpu_reset", if1.cpu_reset, 1);
    chk("rst_view_sel",  if1.view_sel, 0);
    chk("rst_step_out",  if1.step_out, 0);
    chk("rst_rx_data",   if1.rx_data, 8'h00);
    chk("rst_state",     if1.rx_state, RX_IDLE);
    repeat (500) @(negedge clock);
    chk("idle_no_valid", v1_cnt, 0);
    chk("idle_no_ferr",  f1_cnt, 0);
    chk("idle_no_step",  s1_rise, 0);
    chk("idle_cpu_reset", if1.cpu_reset, 1);

    // 'r' releases CPU reset; valid lands 2 sync + 8 + 144 + 1 after the start edge
    send_byte(1, 8'h72, 1'b1, 0, t);
    chk("r_valid_cnt", v1_cnt, 1);
    chk("r_data",      v1_data, 8'h72);
    chk("r_valid_cyc", v1_cyc, t + 155);
    chk("r_cpu_reset", if1.cpu_reset, 0);
    chk("r_rst_cyc",   rst_chg_cyc, t + 156);

    send_byte(1, 8'h32, 1'b1, 0, t);
    chk("v2_valid_cnt", v1_cnt, 2);
    chk("v2_data",      v1_data, 8'h32);
    chk("v2_view_sel",  if1.view_sel, 2'b10);
    chk("v2_view_cyc",  view_chg_cyc, t + 156);

    send_byte(1, CMD_STEP, 1'b1, 0, t);
    repeat (20) @(negedge clock);
    chk("n_rise_cnt", s1_rise, 1);
    chk("n_rise_cyc", s1_rise_cyc, t + 156);
    chk("n_width",    s1_width, 5);

    send_byte(1, 8'h6E, 1'b1, 0, t);
    send_byte(1, 8'h6E, 1'b1, 0, t);
    repeat (20) @(negedge clock);
    chk("nn_rise_cnt", s1_rise, 3);
    chk("nn_width",    s1_width, 5);
    chk("nn_valid_cnt", v1_cnt, 5);

    // second 'n' arrives while the 400-clock pulse is still high
    send_byte(2, 8'h6E, 1'b1, 0, t);
    send_byte(2, 8'h6E, 1'b1, 0, t);
    repeat (300) @(negedge clock);
    chk("long_valid_cnt", v2_cnt, 2);
    chk("long_rise_cnt",  s2_rise, 1);
    chk("long_width",     s2_width, 400);

    // bad stop bit then a held-low line
    send_byte(1, 8'h55, 1'b0, 0, t);
    repeat (40) @(negedge clock);
    if1.rx = 1'b1;
    repeat (10) @(negedge clock);
    chk("fe_ferr_cnt",  f1_cnt, 1);
    chk("fe_valid_cnt", v1_cnt, 5);
    chk("fe_rx_data",   if1.rx_data, 8'h6E);
    chk("fe_state",     if1.rx_state, RX_IDLE);
    chk("fe_overlap",   both_cnt, 0);

    send_byte(1, 8'h31, 1'b1, 0, t);
    chk("after_fe_data", v1_data, 8'h31);
    chk("after_fe_view", if1.view_sel, 2'b01);
    chk("after_fe_cnt",  v1_cnt, 6);

    // 4-clock glitch on an idle line
    if1.rx = 1'b0;
    repeat (4) @(negedge clock);
    if1.rx = 1'b1;
    repeat (30) @(negedge clock);
    chk("gl_valid_cnt", v1_cnt, 6);
    chk("gl_ferr_cnt",  f1_cnt, 1);
    chk("gl_state",     if1.rx_state, RX_IDLE);

    // reset during data bit 4 of 0x33 and during the long step pulse
    send_byte(2, 8'h6E, 1'b1, 0, t);
    send_byte(1, 8'h33, 1'b1, 88, t);
    chk("ab_pre_state", if1.rx_state, RX_DATA);
    chk("ab_pre_step2", if2.step_out, 1);
    reset = 1'b0;
    #1;
    chk("ab_rx_data",   if1.rx_data, 8'h00);
    chk("ab_cpu_reset", if1.cpu_reset, 1);
    chk("ab_view_sel",  if1.view_sel, 0);
    chk("ab_state",     if1.rx_state, RX_IDLE);
    chk("ab_step2",     if2.step_out, 0);
    chk("ab_cpu_reset2", if2.cpu_reset, 1);
    if1.rx = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    repeat (200) @(negedge clock);
    chk("ab_no_valid", v1_cnt, 6);
    chk("ab_no_ferr",  f1_cnt, 1);
    chk("ab_no_step2", s2_rise, 2);

    send_byte(1, 8'h33, 1'b1, 0, t);
    chk("ab_next_data", v1_data, 8'h33);
    chk("ab_next_view", if1.view_sel, 2'b11);
    chk("ab_next_cnt",  v1_cnt, 7);
    chk("end_overlap",  both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/debug_uart_rx.md
# debug_uart_rx

Host-side debug command receiver for the FPGA CPU board: deserialises 8N1 UART bytes from the host on a single RX pin and decodes them into board-control signals, namely the CPU single-step clock, the CPU reset and the 2-bit display view select. It is the input-direction counterpart of the on-board seven-segment debug display. The host can step the CPU and choose which state is shown, instead of relying on the debounced button and slide switches. It sits in the board top level between the RX pin and the CPU/display-mux control inputs.

## Interface
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD, 115200: line rate; BIT_DIV = CLK_FREQ/BAUD (integer division), HALF_DIV = BIT_DIV/2; BIT_DIV ≥ 4 required.
- STEP_CYCLES, 1_000_000: width of the generated step pulse, in clocks; must be ≥ 1.
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  UART line, idle high, asynchronous to clock.
- rx_data  out  8  last good byte received.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- step_out  out  1  CPU single-step clock: high for STEP_CYCLES clocks per step command.
- cpu_reset  out  1  CPU reset level (active-high, matches CPU Reset input).
- view_sel  out  2  display-mux select.

## Operation
- rx passes through a 2-flop synchroniser (reset value 1), and all logic uses the synchronised value rx_s.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on rx_s == 0, load baud counter, go to START.
  - START: after HALF_DIV clocks sample rx_s. If 0, go to DATA with bit index 0. If 1 (glitch), go to IDLE with no output.
  - DATA: every BIT_DIV clocks sample rx_s into shift reg, LSB first. After bit 7, go to STOP.
  - STOP: after BIT_DIV clocks sample rx_s. If 1, latch byte into rx_data, pulse rx_valid, go to IDLE. If 0, pulse frame_err, discard byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s == 1, then go to IDLE. This prevents a break condition being read as a stream of 0x00 bytes.
- The command decoder acts on rx_valid bytes only. Unrecognised bytes update rx_data but are otherwise ignored.
  - 'n' (0x6E): start step pulse. It is ignored while step_out is already high; there is no queueing.
  - 'R' (0x52): cpu_reset ← 1.
  - 'r' (0x72): cpu_reset ← 0.
  - '0'..'3' (0x30..0x33): view_sel ← byte[1:0].
- Step generator: a counter of width clog2(STEP_CYCLES+1) drives step_out high for exactly STEP_CYCLES clocks, then low.
- 'R' does not cancel an in-flight step pulse. The pulse still completes at full width.

## Timing
- Reset values: rx_data 0x00, rx_valid 0, frame_err 0, step_out 0, cpu_reset 1 (CPU held in reset until the host sends 'r'), view_sel 2'b00, FSM IDLE.
- Let t0 be the first clock with rx_s == 0 in IDLE. Then:
  - start sample at t0+HALF_DIV
  - data bit i sample at t0+HALF_DIV+(i+1)·BIT_DIV
  - stop sample at t0+HALF_DIV+9·BIT_DIV
  - rx_valid/frame_err high the clock after the stop sample.
- Pin-to-rx_s latency is 2 clocks.
- Command outputs (view_sel, cpu_reset, step_out rising) update the clock after rx_valid.
- Back-to-back bytes: the FSM is back in IDLE one clock after the stop sample. It can therefore accept a start edge at mid-stop-bit + 1, which tolerates up to ~half-bit clock mismatch.
- reset asserted mid-frame or mid-step: everything returns immediately to reset values. The partial byte is lost and no pulse is produced.
- rx_valid and frame_err are never high together.

## Structure
- Package debug_uart_pkg holds:
  - the rx state enum
  - command byte constants CMD_STEP, CMD_RST_ON, CMD_RST_OFF, CMD_VIEW_BASE
  - the function computing BIT_DIV/HALF_DIV.
- Sub-module uart_rx_core contains the synchroniser, the baud counter, the FSM and the shift register, and outputs rx_data, rx_valid and frame_err.
- The top debug_uart_rx instantiates uart_rx_core and adds the command decoder and step counter.

## Test plan
All scenarios use CLK_FREQ=16, BAUD=1 (BIT_DIV 16, HALF_DIV 8) and STEP_CYCLES=5.
- Reset release, line idle high → cpu_reset=1, view_sel=0, step_out=0, no pulses for 500 clocks.
- Send 0x72 then 0x32 → rx_valid pulses twice with rx_data 0x72/0x32. cpu_reset falls and view_sel=2'b10, each one clock after its rx_valid. Check the rx_valid clock position equals t0+8+144+1 plus sync latency.
- Send 'n' → step_out high exactly 5 clocks. Send 'n','n' back-to-back at full rate → two 5-clock pulses. A second 'n' arriving while step_out is high (use STEP_CYCLES=400) → single pulse only.
- 0x55 with stop bit forced 0, line then held low 40 clocks → one frame_err pulse, no rx_valid, rx_data unchanged. After line returns high, 0x31 is received correctly and view_sel=1.
- 4-clock low glitch on idle line → no rx_valid, no frame_err, FSM back in IDLE.
- Assert reset during data bit 4 of 0x33 and during an active step pulse → all outputs at reset values immediately. Next full byte is received correctly.
